// File: rtl/sseg_mux_decoder.sv
// Receive side of a scanned 4-digit 7-segment bus: synchronises an/sseg, waits for a stable
// window, then decodes the lit digit back to a hex nibble plus decimal point.
module sseg_mux_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic [3:0] valid,
  output logic       upd_tick,
  output logic       err_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

  logic [SYNC_STAGES-1:0][11:0] sync_q, sync_d;
  logic [11:0]                  w, w_d_q, w_d_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [3:0][3:0]              hex_q, hex_d;
  logic [3:0]                   dp_q, dp_d;
  logic [3:0]                   valid_q, valid_d;
  logic                         upd_q, upd_d;
  logic                         err_q, err_d;

  logic       capture;
  logic       seg_ok;
  logic [3:0] nib;
  logic       sel_vld;
  logic [1:0] sel;

  assign w = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = {an, sseg};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    w_d_d = w;

    // Counter saturates so a constant word captures exactly once.
    if (w != w_d_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    capture = (w == w_d_q) && (cnt_q == CNT_CAP);

    seg_ok = 1'b1;
    nib    = 4'h0;
    case (w[6:0])
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    seg_ok = 1'b0;
    endcase

    // Blank or multi-digit anode words are scan gaps, not digits.
    sel_vld = 1'b1;
    sel     = 2'd0;
    case (w[11:8])
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel_vld = 1'b0;
    endcase

    hex_d   = hex_q;
    dp_d    = dp_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    if (capture && sel_vld) begin
      if (seg_ok) begin
        hex_d[sel]   = nib;
        dp_d[sel]    = ~w[7];
        valid_d[sel] = 1'b1;
        upd_d        = 1'b1;
      end else begin
        valid_d[sel] = 1'b0;
        err_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      w_d_q   <= '1;
      cnt_q   <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
      valid_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      w_d_q   <= w_d_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign hex3     = hex_q[3];
  assign hex2     = hex_q[2];
  assign hex1     = hex_q[1];
  assign hex0     = hex_q[0];
  assign dp_out   = dp_q;
  assign valid    = valid_q;
  assign upd_tick = upd_q;
  assign err_tick = err_q;

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Scoreboard bench: stimulus queues the expected post-capture state, a monitor pops it on each tick.
module tb_sseg_mux_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [3:0] hex3, hex2, hex1, hex0, dp_out, valid;
  logic       upd_tick, err_tick;

  typedef struct packed {
    logic        err;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  vld;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [6:0] seg7 [16];

  sseg_mux_decoder dut (
    .clk(clk), .reset(reset), .an(an), .sseg(sseg),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp_out(dp_out), .valid(valid), .upd_tick(upd_tick), .err_tick(err_tick)
  );

  always #5 clk = ~clk;

  // Monitor: every tick must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (upd_tick || err_tick)) begin
      exp_t e;
      checks++;
      if (upd_tick && err_tick) begin
        failures++;
        $display("FAIL both_ticks upd=%b err=%b required not both high", upd_tick, err_tick);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick upd=%b err=%b hex=%h%h%h%h required no tick",
                 upd_tick, err_tick, hex3, hex2, hex1, hex0);
      end else begin
        e = exp_q.pop_front();
        if (err_tick != e.err || {hex3, hex2, hex1, hex0} != e.hex ||
            dp_out != e.dp || valid != e.vld) begin
          failures++;
          $display("FAIL tick err=%b hex=%h dp=%b valid=%b required err=%b hex=%h dp=%b valid=%b",
                   err_tick, {hex3, hex2, hex1, hex0}, dp_out, valid, e.err, e.hex, e.dp, e.vld);
        end
      end
    end
  end

  task automatic apply(input logic [3:0] a, input logic [7:0] s, input int n,
                       input bit cap, input bit er, input logic [15:0] h,
                       input logic [3:0] d, input logic [3:0] v);
    exp_t e;
    if (cap) begin
      e.err = er; e.hex = h; e.dp = d; e.vld = v;
      exp_q.push_back(e);
    end
    an   = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [15:0] h,
                             input logic [3:0] d, input logic [3:0] v);
    checks++;
    if ({hex3, hex2, hex1, hex0} != h || dp_out != d || valid != v) begin
      failures++;
      $display("FAIL %s hex=%h dp=%b valid=%b required hex=%h dp=%b valid=%b",
               name, {hex3, hex2, hex1, hex0}, dp_out, valid, h, d, v);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_tick(input string name, input logic want);
    checks++;
    if (upd_tick != want) begin
      failures++;
      $display("FAIL %s upd_tick=%b required %b", name, upd_tick, want);
    end
  endtask

  initial begin
    seg7[0]  = 7'b0000001; seg7[1]  = 7'b1001111; seg7[2]  = 7'b0010010; seg7[3]  = 7'b0000110;
    seg7[4]  = 7'b1001100; seg7[5]  = 7'b0100100; seg7[6]  = 7'b0100000; seg7[7]  = 7'b0001111;
    seg7[8]  = 7'b0000000; seg7[9]  = 7'b0000100; seg7[10] = 7'b0001000; seg7[11] = 7'b1100000;
    seg7[12] = 7'b0110001; seg7[13] = 7'b1000010; seg7[14] = 7'b0110000; seg7[15] = 7'b0111000;

    reset = 1'b1;
    an    = 4'hF;
    sseg  = 8'hFF;
    repeat (3) @(negedge clk);
    check_state("reset_state", 16'h0000, 4'b0000, 4'b0000);
    check_tick("reset_tick", 1'b0);

    // Digit 0 shows "0"; first capture lands on edge 18 after release.
    apply(4'b1110, 8'h81, 0, 1, 0, 16'h0000, 4'b0000, 4'b0001);
    reset = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check_tick("lat_early", 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_tick("lat_hit", 1'b1);
    repeat (10) @(negedge clk);
    check_drained("t1_drain");
    check_state("t1_state", 16'h0000, 4'b0000, 4'b0001);

    // Two scans of 1,2.,3,F on digits 3..0.
    for (int k = 0; k < 2; k++) begin
      apply(4'b0111, 8'hCF, 64, 1, 0, (k == 0) ? 16'h1000 : 16'h123F,
            (k == 0) ? 4'b0000 : 4'b0100, (k == 0) ? 4'b1001 : 4'b1111);
      apply(4'b1011, 8'h12, 64, 1, 0, (k == 0) ? 16'h1200 : 16'h123F, 4'b0100,
            (k == 0) ? 4'b1101 : 4'b1111);
      apply(4'b1101, 8'h86, 64, 1, 0, 16'h123F & ((k == 0) ? 16'hFFF0 : 16'hFFFF), 4'b0100, 4'b1111);
      apply(4'b1110, 8'hB8, 64, 1, 0, 16'h123F, 4'b0100, 4'b1111);
    end
    check_drained("t2_drain");
    check_state("t2_state", 16'h123F, 4'b0100, 4'b1111);

    // 15-cycle window is one short; the following blank word is ignored.
    apply(4'b1110, 8'h80, 15, 0, 0, 0, 0, 0);
    apply(4'b1111, 8'hFF, 100, 0, 0, 0, 0, 0);
    check_drained("t3_drain");
    check_state("t3_state", 16'h123F, 4'b0100, 4'b1111);

    apply(4'b1010, 8'h80, 100, 0, 0, 0, 0, 0);
    check_drained("t4_drain");
    check_state("t4_state", 16'h123F, 4'b0100, 4'b1111);

    // "5" on digit 1, then an undecodable pattern on the same digit.
    apply(4'b1101, 8'hA4, 40, 1, 0, 16'h125F, 4'b0100, 4'b1111);
    apply(4'b1101, 8'hFE, 40, 1, 1, 16'h125F, 4'b0100, 4'b1101);
    check_drained("t5_drain");
    check_state("t5_state", 16'h125F, 4'b0100, 4'b1101);

    // Full decode table walked on digit 0.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n4;
      n4 = 4'(i);
      apply(4'b1110, {1'b1, seg7[i]}, 24, 1, 0, {12'h125, n4}, 4'b0100, 4'b1101);
    end
    check_drained("walk_drain");
    check_state("walk_state", 16'h125F, 4'b0100, 4'b1101);

    // Reset five cycles into a window of "7." on digit 0.
    apply(4'b1110, 8'h0F, 5, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_state("t6_in_reset", 16'h0000, 4'b0000, 4'b0000);
    apply(4'b1110, 8'h0F, 0, 1, 0, 16'h0007, 4'b0001, 4'b0001);
    reset = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check_tick("t6_early", 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_tick("t6_hit", 1'b1);
    repeat (10) @(negedge clk);
    check_drained("t6_drain");
    check_state("t6_state", 16'h0007, 4'b0001, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
